// File: rtl/vm_result_rx_if.sv
// Beat bus carrying the vending machine's serial result burst into vm_result_rx.
interface vm_result_rx_if #(
  parameter int unsigned COIN_W = 4,
  parameter int unsigned SELL_W = 6
);
  logic              in_valid;
  logic [COIN_W-1:0] in_consumer;
  logic [SELL_W-1:0] in_sell_num;
  logic [10:0]       in_exp_change;

  modport master (output in_valid, in_consumer, in_sell_num, in_exp_change);
  modport slave  (input  in_valid, in_consumer, in_sell_num, in_exp_change);
endinterface

// File: rtl/vm_result_rx.sv
// Deserializes the 6-beat vending result burst, commits change/sold totals and per-item counts.
// Optional change cross-check against in_exp_change is enabled by defining VM_RX_CHECK_EN.
module vm_result_rx #(
  parameter int unsigned COIN_W = 4,
  parameter int unsigned SELL_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  vm_result_rx_if.slave     bus,
  input  logic [2:0]        rd_sel,
  output logic [SELL_W-1:0] rd_sell_num,
  output logic [10:0]       out_change,
  output logic              out_dispensed,
  output logic [8:0]        out_sell_total,
  output logic              out_frame_done,
  output logic              out_frame_err,
  output logic              out_mismatch
);

  localparam int unsigned CHG_W = 11;
  localparam int unsigned TOT_W = 9;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned NBEAT = 6;
  localparam int unsigned NCOIN = 5;

  typedef enum logic [1:0] {IDLE, RECV, DONE, DRAIN} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          cap_c;
  logic [CNT_W-1:0]              cap_idx_c;
  logic                          commit_c;
  logic                          err_c;

  logic                          disp_sh_q;
  logic [NCOIN-1:0][COIN_W-1:0]  coin_sh_q;
  logic [NBEAT-1:0][SELL_W-1:0]  sell_sh_q;
  logic [NBEAT-1:0][SELL_W-1:0]  item_q;

  logic [CHG_W-1:0]              change_c;
  logic [TOT_W-1:0]              tot_c;
  logic [SELL_W-1:0]             rd_c;

  logic [CHG_W-1:0]              change_q;
  logic                          disp_q;
  logic [TOT_W-1:0]              tot_q;
  logic                          done_q;
  logic                          err_q;
  logic [SELL_W-1:0]             rd_q;

  // State register and beat counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: beat capture, commit and error decisions
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_c     = 1'b0;
    cap_idx_c = cnt_q;
    commit_c  = 1'b0;
    err_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cap_c     = 1'b1;
          cap_idx_c = '0;
          cnt_d     = CNT_W'(1);
          state_d   = RECV;
        end
      end
      RECV: begin
        if (bus.in_valid) begin
          cap_c = 1'b1;
          if (cnt_q == CNT_W'(NBEAT - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          err_c   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        commit_c = 1'b1;
        if (bus.in_valid) begin
          err_c   = 1'b1;
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!bus.in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow registers: beat0 holds the dispense flag, beats 1-5 the coin counts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_sh_q <= 1'b0;
      coin_sh_q <= '0;
      sell_sh_q <= '0;
    end else if (cap_c) begin
      sell_sh_q[cap_idx_c] <= bus.in_sell_num;
      if (cap_idx_c == '0) begin
        disp_sh_q <= bus.in_consumer[0];
      end else begin
        coin_sh_q[cap_idx_c - CNT_W'(1)] <= bus.in_consumer;
      end
    end
  end

  // Change and sold-total reconstruction; both fit their widths at maximum input
  always_comb begin
    change_c = CHG_W'(50) * CHG_W'(coin_sh_q[0])
             + CHG_W'(20) * CHG_W'(coin_sh_q[1])
             + CHG_W'(10) * CHG_W'(coin_sh_q[2])
             + CHG_W'(5)  * CHG_W'(coin_sh_q[3])
             + CHG_W'(coin_sh_q[4]);
    tot_c = '0;
    for (int i = 0; i < int'(NBEAT); i++) begin
      tot_c = tot_c + TOT_W'(sell_sh_q[i]);
    end
  end

  // Readback mux over committed items only; 0 and 7 select nothing
  always_comb begin
    rd_c = '0;
    if (rd_sel != 3'd0 && rd_sel != 3'd7) begin
      rd_c = item_q[rd_sel - 3'd1];
    end
  end

  // Committed outputs and pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      change_q <= '0;
      disp_q   <= 1'b0;
      tot_q    <= '0;
      item_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      done_q <= commit_c;
      err_q  <= err_c;
      rd_q   <= rd_c;
      if (commit_c) begin
        change_q <= change_c;
        disp_q   <= disp_sh_q;
        tot_q    <= tot_c;
        item_q   <= sell_sh_q;
      end
    end
  end

`ifdef VM_RX_CHECK_EN
  logic mismatch_q;

  // Sticky change mismatch, re-evaluated on every commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else if (commit_c) begin
      mismatch_q <= (change_c != bus.in_exp_change);
    end
  end

  assign out_mismatch = mismatch_q;
`else
  logic unused_exp_c;
  assign unused_exp_c = ^bus.in_exp_change;
  assign out_mismatch = 1'b0;
`endif

  assign rd_sell_num    = rd_q;
  assign out_change     = change_q;
  assign out_dispensed  = disp_q;
  assign out_sell_total = tot_q;
  assign out_frame_done = done_q;
  assign out_frame_err  = err_q;

endmodule
